// File: rtl/sigmoid_backward.sv
// rtl/sigmoid_backward.sv - two-stage valid/ready sigmoid derivative (grad * s * (1 - s)) per lane
//
// Purpose: for every lane, scales the upstream gradient by the sigmoid
// derivative rebuilt from the stored forward activation. Both the activation
// and the gradient are signed fixed point with S fractional bits.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input beat valid
//   in_ready   out  input beat accepted this cycle (combinational from out_ready)
//   en         in   1 = apply derivative, 0 = pass grad through; bound to the beat
//   in_last    in   last vector of tile; bound to the beat
//   act        in   SA_LENGTH x DATA_WIDTH stored sigmoid outputs (lane 0 in LSBs)
//   grad       in   SA_LENGTH x DATA_WIDTH upstream gradient (lane 0 in LSBs)
//   out_valid  out  output beat valid
//   out_ready  in   downstream accepts the output beat
//   out_last   out  in_last of the presented output beat
//   out        out  SA_LENGTH x DATA_WIDTH result (lane 0 in LSBs)
module sigmoid_backward #(
  parameter int DATA_WIDTH = 12,
  parameter int SA_LENGTH  = 7,
  parameter int S          = 7
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            en,
  input  logic                            in_last,
  input  logic [SA_LENGTH*DATA_WIDTH-1:0] act,
  input  logic [SA_LENGTH*DATA_WIDTH-1:0] grad,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic [SA_LENGTH*DATA_WIDTH-1:0] out
);

  localparam int DW = DATA_WIDTH;
  localparam int VW = SA_LENGTH * DATA_WIDTH;
  // p1 = a*(1-a) peaks at 2^(S-2), which needs S-1 bits.
  localparam int QW = S - 1;
  // Signed gradient times zero-extended p1.
  localparam int PW = DW + S;

  localparam logic [DW-1:0] ONE_DW = DW'(1) << S;
  localparam logic [S:0]    ONE_A  = {1'b1, {S{1'b0}}};

  // Stage 1 registers
  logic              s1_valid_q;
  logic              s1_en_q;
  logic              s1_last_q;
  logic [VW-1:0]     s1_grad_q;
  logic [SA_LENGTH*QW-1:0] s1_p1_q;
  logic [SA_LENGTH*QW-1:0] p1_d;

  // Stage 2 registers (drive the outputs directly)
  logic              s2_valid_q;
  logic              s2_last_q;
  logic [VW-1:0]     s2_data_q;
  logic [VW-1:0]     out_d;

  logic s1_adv;
  logic s2_adv;

  // Bubbles collapse: a stage may load whenever it is empty or the stage
  // after it is moving. The ready path is purely combinational.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  genvar i;
  for (i = 0; i < SA_LENGTH; i++) begin : g_lane
    logic [DW-1:0]        act_l;
    logic [S:0]           a;
    logic [S:0]           m;
    logic [2*S+1:0]       am;
    logic [DW-1:0]        g;
    logic [QW-1:0]        p;
    logic signed [PW-1:0] gp;

    assign act_l = act[i*DW +: DW];

    // Clamp the stored activation into [0, 1.0]
    always_comb begin
      if (act_l[DW-1]) begin
        a = '0;
      end else if (act_l > ONE_DW) begin
        a = ONE_A;
      end else begin
        a = act_l[S:0];
      end
    end

    assign m  = ONE_A - a;
    assign am = {{(S+1){1'b0}}, a} * {{(S+1){1'b0}}, m};
    assign p1_d[i*QW +: QW] = QW'(am >> S);

    assign g  = s1_grad_q[i*DW +: DW];
    assign p  = s1_p1_q[i*QW +: QW];
    assign gp = $signed({{S{g[DW-1]}}, g}) * $signed({{(DW+1){1'b0}}, p});

    // Arithmetic shift floors toward -inf; |result| <= |grad|/4 so the
    // truncation back to DW bits cannot overflow.
    assign out_d[i*DW +: DW] = s1_en_q ? DW'(gp >>> S) : g;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_en_q    <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_grad_q  <= '0;
      s1_p1_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_en_q   <= en;
          s1_last_q <= in_last;
          s1_grad_q <= grad;
          s1_p1_q   <= p1_d;
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_last_q <= s1_last_q;
          s2_data_q <= out_d;
        end
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_last  = s2_last_q;
  assign out       = s2_data_q;

endmodule

// File: tb/tb_sigmoid_backward.sv
// tb/tb_sigmoid_backward.sv - self-checking bench for sigmoid_backward
module tb_sigmoid_backward;

  localparam int DW = 12;
  localparam int SA = 7;
  localparam int S  = 7;
  localparam int VW = SA * DW;
  localparam int CW = 96;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          en;
  logic          in_last;
  logic [VW-1:0] act;
  logic [VW-1:0] grad;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [VW-1:0] out;

  sigmoid_backward #(.DATA_WIDTH(DW), .SA_LENGTH(SA), .S(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .en        (en),
    .in_last   (in_last),
    .act       (act),
    .grad      (grad),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out       (out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_out  = 0;

  logic [VW-1:0] exp_q[$];
  logic          last_q[$];
  logic          stall_prev = 1'b0;
  logic [VW-1:0] held_out;
  logic          held_last;

  int core_act[SA]  = '{64, 0, 128, 200, -5, 64, 64};
  int core_grad[SA] = '{128, 2047, 2047, 2047, 2047, -2048, -1};
  int core_exp[SA]  = '{32, 0, 0, 0, 0, -512, -1};
  int pt_grad[SA]   = '{0, 400, 517, -512, -1, -2048, 2047};
  int all64[SA]     = '{64, 64, 64, 64, 64, 64, 64};

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] pack(input int v[SA]);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < SA; i++) r[i*DW +: DW] = DW'(v[i]);
    return r;
  endfunction

  function automatic logic [VW-1:0] model(input logic [VW-1:0] a_v, input logic [VW-1:0] g_v,
                                          input logic e);
    logic [VW-1:0] r;
    logic [DW-1:0] lane;
    int a, g, p, o;
    r = '0;
    for (int i = 0; i < SA; i++) begin
      lane = a_v[i*DW +: DW];
      a = $signed(lane);
      lane = g_v[i*DW +: DW];
      g = $signed(lane);
      if (a < 0) a = 0;
      else if (a > (1 << S)) a = 1 << S;
      p = (a * ((1 << S) - a)) >> S;
      o = e ? ((g * p) >>> S) : g;
      r[i*DW +: DW] = o[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_act();
    logic [VW-1:0] r;
    for (int i = 0; i < SA; i++) r[i*DW +: DW] = DW'($urandom_range(0, 176)) - DW'(24);
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_grad();
    logic [VW-1:0] r;
    for (int i = 0; i < SA; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: predicts every accepted beat and checks every consumed beat,
  // plus output stability while the consumer stalls.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      last_q.delete();
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_data", out, held_out);
        check("stall_last", out_last, held_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", out_valid, 1'b0);
        end else begin
          check("out_data", out, exp_q.pop_front());
          check("out_last", out_last, last_q.pop_front());
        end
        n_out++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(act, grad, en));
        last_q.push_back(in_last);
      end
      stall_prev <= out_valid && !out_ready;
      held_out   <= out;
      held_last  <= out_last;
    end
  end

  initial begin
    logic [VW-1:0] bp_a[4];
    logic [VW-1:0] bp_g[4];
    logic [VW-1:0] ra, rg;
    int idx, base, sent, cyc;
    logic acc;

    clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; en = 1'b0; in_last = 1'b0;
    act = '0; grad = '0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out", out, '0);
    check("reset_out_last", out_last, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Core values, en=1
    out_ready = 1'b1;
    act = pack(core_act); grad = pack(core_grad); en = 1'b1; in_last = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    check("core_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("core_early_valid", out_valid, 1'b0);
    tick();
    @(negedge clk);
    check("core_valid", out_valid, 1'b1);
    check("core_data", out, pack(core_exp));
    check("core_last", out_last, 1'b1);
    tick();
    @(negedge clk);
    check("core_single_beat", out_valid, 1'b0);

    // Passthrough, en=0
    act = pack(all64); grad = pack(pt_grad); en = 1'b0; in_last = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    check("pass_valid", out_valid, 1'b1);
    check("pass_data", out, pack(pt_grad));
    check("pass_last", out_last, 1'b0);
    tick();

    // Streaming: 16 back-to-back beats, en toggling, last on beat 16
    base = n_out;
    for (int k = 0; k < 16; k++) begin
      act = rand_act(); grad = rand_grad(); en = k[0]; in_last = (k == 15); in_valid = 1'b1;
      @(negedge clk);
      check("stream_in_ready", in_ready, 1'b1);
      if (k >= 2) check("stream_out_valid", out_valid, 1'b1);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    repeat (3) tick();
    check("stream_count", n_out - base, 16);

    // Backpressure: out_ready low for 5 cycles with in_valid held high
    for (int k = 0; k < 4; k++) begin
      bp_a[k] = rand_act();
      bp_g[k] = rand_grad();
    end
    out_ready = 1'b0;
    idx = 0;
    base = n_out;
    for (int c = 0; c < 5; c++) begin
      act = bp_a[idx]; grad = bp_g[idx]; en = ~idx[0]; in_last = (idx == 3); in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      if (c >= 2) check("bp_ready_low", in_ready, 1'b0);
      tick();
      if (acc) idx++;
    end
    check("bp_accepts", idx, 2);
    check("bp_hold_valid", out_valid, 1'b1);
    check("bp_hold_data", out, model(bp_a[0], bp_g[0], 1'b1));
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (idx < 4) begin
        act = bp_a[idx]; grad = bp_g[idx]; en = ~idx[0]; in_last = (idx == 3); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
    end
    check("bp_drain_count", n_out - base, 4);

    // Random valid/ready over 1000 beats
    base = n_out; sent = 0; cyc = 0;
    act = rand_act(); grad = rand_grad(); en = $urandom_range(0, 1) != 0; in_last = 1'b0;
    while (sent < 1000 && cyc < 20000) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      cyc++;
      if (acc) begin
        sent++;
        act = rand_act(); grad = rand_grad(); en = $urandom_range(0, 1) != 0;
        in_last = (sent % 8) == 7;
      end
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    check("rand_sent", sent, 1000);
    check("rand_count", n_out - base, 1000);
    check("rand_queue_empty", exp_q.size(), 0);

    // Reset with two beats in flight
    out_ready = 1'b0;
    act = rand_act(); grad = rand_grad(); en = 1'b1; in_valid = 1'b1;
    tick();
    act = rand_act(); grad = rand_grad();
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_valid", out_valid, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out", out, '0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_no_partial", out_valid, 1'b0);
    base = n_out;
    ra = rand_act(); rg = rand_grad();
    out_ready = 1'b1; act = ra; grad = rg; en = 1'b1; in_last = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    @(negedge clk);
    check("rst_first_valid", out_valid, 1'b1);
    check("rst_first_data", out, model(ra, rg, 1'b1));
    check("rst_first_last", out_last, 1'b1);
    tick();
    check("rst_first_count", n_out - base, 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
